alert_dispatcher: RTL and testbench
===================================

ALERT_DISPATCHER -- requirements
Module: alert_dispatcher

Interface
REQ-001 Parameter ESC_CYCLES, default 30_000_000: unacknowledged-alert cycles before escalation (30 s at 1 MHz).
REQ-002 Parameter DEB_CYCLES, default 8: consecutive high cycles that qualify bpm_state, temp_high or temp_low.
REQ-003 Parameter BLINK_CYCLES, default 250_000: buzzer half-period in ESCALATE.
REQ-004 clk  in  1  system clock, 1 MHz.
REQ-005 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-006 fall_alarm  in  1  from fall detection; rising edge = event.
REQ-007 bpm_state  in  1  from BPM monitor; 1 = heart rate out of range.
REQ-008 temp_high  in  1  from temperature monitor; 1 = fever.
REQ-009 temp_low  in  1  from temperature monitor; 1 = hypothermia.
REQ-010 medicine_reminder  in  1  from medicine reminder; rising edge = event.
REQ-011 caregiver_ack  in  1  synchronous acknowledge; one-cycle pulse or level.
REQ-012 alert_valid  out  1  an alert is being presented.
REQ-013 alert_code  out  3  0 none, 1 fall, 2 bpm, 3 temp_high, 4 temp_low, 5 medicine.
REQ-014 escalate  out  1  alert unacknowledged for ESC_CYCLES.
REQ-015 buzzer  out  1  audible drive.
REQ-016 pending  out  5  sticky pending bits, bit0 fall .. bit4 medicine.

Function
REQ-017 fall_alarm and medicine_reminder SHALL set their pending bit on the cycle after a 0->1 transition is sampled.
REQ-018 bpm_state, temp_high, temp_low SHALL each set their pending bit once on the cycle their high run reaches DEB_CYCLES; a drop to 0 restarts the count; no re-set until the input has returned to 0.
REQ-019 Priority SHALL be fall > bpm > temp_high > temp_low > medicine.
REQ-020 FSM states IDLE, ALERT, ESCALATE, GAP.
REQ-021 IDLE -> ALERT the cycle after any pending bit is 1; alert_code latches the highest-priority pending source, alert_valid=1, timer cleared.
REQ-022 ALERT: timer increments each cycle; at timer = ESC_CYCLES-1 without ack -> ESCALATE.
REQ-023 ALERT or ESCALATE with caregiver_ack=1: clear pending bit of alert_code, go to GAP; alert_valid=0, alert_code=0 next cycle.
REQ-024 GAP lasts exactly one cycle, then IDLE; caregiver_ack held high SHALL NOT clear a later alert until it has been sampled 0 once.
REQ-025 caregiver_ack in IDLE or GAP SHALL be ignored.
REQ-026 Fall pending while alert_code is not 1: preempt next cycle; alert_code=1, timer restarts, state ALERT, escalate=0; preempted bit stays pending.
REQ-027 Lower-priority events during ALERT/ESCALATE SHALL only set pending bits.
REQ-028 Same-cycle ack and new event on the served source: set wins; bit stays 1.
REQ-029 Repeat event on an already-pending source SHALL be absorbed (no counter, no duplicate).
REQ-030 escalate=1 only in ESCALATE.
REQ-031 buzzer: 1 steady in ALERT for codes 1-4; 0 for code 5 in ALERT; toggles every BLINK_CYCLES in ESCALATE for any code; 0 in IDLE/GAP.
REQ-032 Timer width ceil(log2(ESC_CYCLES))+1 bits; saturates, never wraps.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, pending=0, alert_valid=0, alert_code=0, escalate=0, buzzer=0, all counters and edge registers 0.
REQ-034 Inputs high at reset release SHALL NOT count as rising edges; level sources begin debouncing from 0.

Structure
REQ-035 Package alert_pkg SHALL hold state encoding, alert_code constants and default parameter values.
REQ-036 Sub-module level_qualifier (debounce + one-shot) SHALL be instantiated three times.

Verification (ESC_CYCLES=100, DEB_CYCLES=8, BLINK_CYCLES=10)
REQ-037 fall_alarm pulse, no ack -> alert_code=1 after 2 cycles; escalate=1 100 cycles later; buzzer toggles every 10.
REQ-038 bpm_state high 7 cycles, low, high 8 -> no pending after first run; pending[1]=1 after second.
REQ-039 medicine then temp_high one cycle apart, acks -> codes 5, then GAP, then 3; buzzer 0 during code 5.
REQ-040 temp_low presenting, fall_alarm rises -> code 1 next cycle, pending[3] still 1; ack -> GAP -> code 4.
REQ-041 Ack same cycle as new medicine edge while code 5 -> GAP, then code 5 again.
REQ-042 reset=0 mid-ESCALATE -> all outputs 0 asynchronously; held-high fall_alarm at release -> no alert.

Source files
------------

// File: rtl/alert_pkg.sv
// Shared definitions for the alert dispatcher: FSM encoding, alert codes,
// default timing parameters and the source-priority encoder.
package alert_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALERT    = 2'd1,
    ST_ESCALATE = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_FALL      = 3'd1;
  localparam logic [2:0] CODE_BPM       = 3'd2;
  localparam logic [2:0] CODE_TEMP_HIGH = 3'd3;
  localparam logic [2:0] CODE_TEMP_LOW  = 3'd4;
  localparam logic [2:0] CODE_MEDICINE  = 3'd5;

  localparam int unsigned ESC_CYCLES_DEF   = 30_000_000;
  localparam int unsigned DEB_CYCLES_DEF   = 8;
  localparam int unsigned BLINK_CYCLES_DEF = 250_000;

  // Pending bit i maps to alert code i+1; lower bit index wins.
  function automatic logic [2:0] top_code(input logic [4:0] pend);
    logic [2:0] code;
    code = CODE_NONE;
    if (pend[0])      code = CODE_FALL;
    else if (pend[1]) code = CODE_BPM;
    else if (pend[2]) code = CODE_TEMP_HIGH;
    else if (pend[3]) code = CODE_TEMP_LOW;
    else if (pend[4]) code = CODE_MEDICINE;
    return code;
  endfunction

endpackage

// File: rtl/level_qualifier.sv
// Debounce + one-shot: fires once when a level has been high for DEB_CYCLES
// consecutive samples, and re-arms only after the level returns to 0.
module level_qualifier
  import alert_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic fire
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] count_reg;
  logic          fired_reg;

  assign fire = level && !fired_reg && (count_reg == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      fired_reg <= 1'b0;
    end else if (!level) begin
      count_reg <= '0;
      fired_reg <= 1'b0;
    end else if (!fired_reg) begin
      if (fire) begin
        count_reg <= '0;
        fired_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alert_dispatcher.sv
// Collects alert sources into sticky pending bits and presents the most
// urgent one to the caregiver, escalating when it goes unacknowledged.
module alert_dispatcher
  import alert_pkg::*;
#(
  parameter int unsigned ESC_CYCLES   = ESC_CYCLES_DEF,
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int unsigned BLINK_CYCLES = BLINK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fall_alarm,
  input  logic       bpm_state,
  input  logic       temp_high,
  input  logic       temp_low,
  input  logic       medicine_reminder,
  input  logic       caregiver_ack,
  output logic       alert_valid,
  output logic [2:0] alert_code,
  output logic       escalate,
  output logic       buzzer,
  output logic [4:0] pending
);

  localparam int TW = $clog2(ESC_CYCLES) + 1;
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  state_t        state_reg;
  logic [2:0]    code_reg;
  logic          valid_reg;
  logic          esc_reg;
  logic          buzz_reg;
  logic [TW-1:0] timer_reg;
  logic [BW-1:0] blink_reg;
  logic [4:0]    pending_reg;
  logic [4:0]    pending_next;
  logic          armed_reg;
  logic          fall_prev_reg;
  logic          med_prev_reg;
  logic          ack_block_reg;

  logic [2:0] levels;
  logic [2:0] level_fire;
  logic       fall_rise;
  logic       med_rise;
  logic [4:0] set_bits;
  logic [4:0] clr_bits;
  logic       ack_ok;

  assign levels = {temp_low, temp_high, bpm_state};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_level
      level_qualifier #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_level_qualifier (
        .clk  (clk),
        .reset(reset),
        .level(levels[gi]),
        .fire (level_fire[gi])
      );
    end
  endgenerate

  // armed_reg masks the first sample after reset so levels already high
  // at release are not mistaken for rising edges.
  assign fall_rise = armed_reg && fall_alarm && !fall_prev_reg;
  assign med_rise  = armed_reg && medicine_reminder && !med_prev_reg;
  assign set_bits  = {med_rise, level_fire, fall_rise};

  assign ack_ok = caregiver_ack && !ack_block_reg &&
                  ((state_reg == ST_ALERT) || (state_reg == ST_ESCALATE));

  always_comb begin
    clr_bits = '0;
    if (ack_ok) begin
      case (code_reg)
        CODE_FALL:      clr_bits[0] = 1'b1;
        CODE_BPM:       clr_bits[1] = 1'b1;
        CODE_TEMP_HIGH: clr_bits[2] = 1'b1;
        CODE_TEMP_LOW:  clr_bits[3] = 1'b1;
        CODE_MEDICINE:  clr_bits[4] = 1'b1;
        default:        clr_bits = '0;
      endcase
    end
  end

  // A new event on the source being cleared keeps its bit set.
  assign pending_next = (pending_reg & ~clr_bits) | set_bits;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_reg     <= 1'b0;
      fall_prev_reg <= 1'b0;
      med_prev_reg  <= 1'b0;
      pending_reg   <= '0;
      ack_block_reg <= 1'b0;
    end else begin
      armed_reg     <= 1'b1;
      fall_prev_reg <= fall_alarm;
      med_prev_reg  <= medicine_reminder;
      pending_reg   <= pending_next;
      if (!caregiver_ack)
        ack_block_reg <= 1'b0;
      else if (ack_ok)
        ack_block_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      code_reg  <= CODE_NONE;
      valid_reg <= 1'b0;
      esc_reg   <= 1'b0;
      buzz_reg  <= 1'b0;
      timer_reg <= '0;
      blink_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|pending_reg) begin
            state_reg <= ST_ALERT;
            code_reg  <= top_code(pending_reg);
            valid_reg <= 1'b1;
            esc_reg   <= 1'b0;
            buzz_reg  <= (top_code(pending_reg) != CODE_MEDICINE);
            timer_reg <= '0;
            blink_reg <= '0;
          end
        end
        ST_ALERT, ST_ESCALATE: begin
          if (ack_ok) begin
            state_reg <= ST_GAP;
            code_reg  <= CODE_NONE;
            valid_reg <= 1'b0;
            esc_reg   <= 1'b0;
            buzz_reg  <= 1'b0;
            timer_reg <= '0;
            blink_reg <= '0;
          end else if (pending_reg[0] && (code_reg != CODE_FALL)) begin
            state_reg <= ST_ALERT;
            code_reg  <= CODE_FALL;
            esc_reg   <= 1'b0;
            buzz_reg  <= 1'b1;
            timer_reg <= '0;
            blink_reg <= '0;
          end else begin
            if (timer_reg != {TW{1'b1}})
              timer_reg <= timer_reg + 1'b1;
            if (state_reg == ST_ALERT) begin
              if (timer_reg == TW'(ESC_CYCLES - 1)) begin
                state_reg <= ST_ESCALATE;
                esc_reg   <= 1'b1;
                buzz_reg  <= 1'b1;
                blink_reg <= '0;
              end
            end else if (blink_reg == BW'(BLINK_CYCLES - 1)) begin
              blink_reg <= '0;
              buzz_reg  <= !buzz_reg;
            end else begin
              blink_reg <= blink_reg + 1'b1;
            end
          end
        end
        ST_GAP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign alert_valid = valid_reg;
  assign alert_code  = code_reg;
  assign escalate    = esc_reg;
  assign buzzer      = buzz_reg;
  assign pending     = pending_reg;

endmodule

// File: tb/tb_alert_dispatcher.sv
// Directed bench for alert_dispatcher: a cycle table for ack/priority cases
// followed by hand sequences for debounce, escalation, blink and reset.
module tb_alert_dispatcher;

  logic       clk;
  logic       reset;
  logic       fall_alarm;
  logic       bpm_state;
  logic       temp_high;
  logic       temp_low;
  logic       medicine_reminder;
  logic       caregiver_ack;
  logic       alert_valid;
  logic [2:0] alert_code;
  logic       escalate;
  logic       buzzer;
  logic [4:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  alert_dispatcher #(
    .ESC_CYCLES  (100),
    .DEB_CYCLES  (8),
    .BLINK_CYCLES(10)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fall_alarm       (fall_alarm),
    .bpm_state        (bpm_state),
    .temp_high        (temp_high),
    .temp_low         (temp_low),
    .medicine_reminder(medicine_reminder),
    .caregiver_ack    (caregiver_ack),
    .alert_valid      (alert_valid),
    .alert_code       (alert_code),
    .escalate         (escalate),
    .buzzer           (buzzer),
    .pending          (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stim = {fall, bpm, temp_high, temp_low, medicine, ack}
  // expv = {valid, code[2:0], escalate, buzzer, pending[4:0]}
  typedef struct packed {
    logic [5:0]  stim;
    logic [10:0] expv;
  } vec_t;

  vec_t vecs [0:24];

  function automatic logic [10:0] o(input logic v, input logic [2:0] c,
                                    input logic e, input logic b,
                                    input logic [4:0] p);
    return {v, c, e, b, p};
  endfunction

  function automatic logic [10:0] obs();
    return {alert_valid, alert_code, escalate, buzzer, pending};
  endfunction

  task automatic drive(input logic [5:0] s);
    {fall_alarm, bpm_state, temp_high, temp_low, medicine_reminder, caregiver_ack} = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got v=%b code=%0d esc=%b buz=%b pend=%b, expected v=%b code=%0d esc=%b buz=%b pend=%b",
               name, act[10], act[9:7], act[6], act[5], act[4:0],
               expv[10], expv[9:7], expv[6], expv[5], expv[4:0]);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  initial begin
    vecs[0]  = {6'b000000, o(0, 0, 0, 0, 5'b00000)};
    vecs[1]  = {6'b000010, o(0, 0, 0, 0, 5'b10000)};
    vecs[2]  = {6'b000010, o(1, 5, 0, 0, 5'b10000)};
    vecs[3]  = {6'b000000, o(1, 5, 0, 0, 5'b10000)};
    vecs[4]  = {6'b000001, o(0, 0, 0, 0, 5'b00000)};
    vecs[5]  = {6'b000001, o(0, 0, 0, 0, 5'b00000)};
    vecs[6]  = {6'b000011, o(0, 0, 0, 0, 5'b10000)};
    vecs[7]  = {6'b000011, o(1, 5, 0, 0, 5'b10000)};
    vecs[8]  = {6'b000001, o(1, 5, 0, 0, 5'b10000)};
    vecs[9]  = {6'b000000, o(1, 5, 0, 0, 5'b10000)};
    vecs[10] = {6'b000001, o(0, 0, 0, 0, 5'b00000)};
    vecs[11] = {6'b000000, o(0, 0, 0, 0, 5'b00000)};
    vecs[12] = {6'b000010, o(0, 0, 0, 0, 5'b10000)};
    vecs[13] = {6'b000010, o(1, 5, 0, 0, 5'b10000)};
    vecs[14] = {6'b000000, o(1, 5, 0, 0, 5'b10000)};
    vecs[15] = {6'b000011, o(0, 0, 0, 0, 5'b10000)};
    vecs[16] = {6'b000000, o(0, 0, 0, 0, 5'b10000)};
    vecs[17] = {6'b000000, o(1, 5, 0, 0, 5'b10000)};
    vecs[18] = {6'b100000, o(1, 5, 0, 0, 5'b10001)};
    vecs[19] = {6'b100000, o(1, 1, 0, 1, 5'b10001)};
    vecs[20] = {6'b000001, o(0, 0, 0, 0, 5'b10000)};
    vecs[21] = {6'b000000, o(0, 0, 0, 0, 5'b10000)};
    vecs[22] = {6'b000000, o(1, 5, 0, 0, 5'b10000)};
    vecs[23] = {6'b000001, o(0, 0, 0, 0, 5'b00000)};
    vecs[24] = {6'b000000, o(0, 0, 0, 0, 5'b00000)};

    reset = 1'b0;
    drive(6'b000000);
    #2;
    chk("reset_state", obs(), o(0, 0, 0, 0, 5'b00000));
    step();
    step();
    reset = 1'b1;
    step();

    // Table: medicine alerts, ack gap, held-ack blocking, same-cycle set/clear, fall preemption
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].stim);
      step();
      $display("vec %0d stim=%b out=%b", i, vecs[i].stim, obs());
      chk($sformatf("vec%0d", i), obs(), vecs[i].expv);
    end

    // bpm: 7-cycle run does not qualify, 8-cycle run does, once only
    drive(6'b010000);
    for (int i = 0; i < 7; i++) step();
    drive(6'b000000);
    step();
    chk("bpm_short_run", obs(), o(0, 0, 0, 0, 5'b00000));
    drive(6'b010000);
    for (int i = 0; i < 7; i++) step();
    chk("bpm_7_of_8", obs(), o(0, 0, 0, 0, 5'b00000));
    step();
    chk("bpm_qualified", obs(), o(0, 0, 0, 0, 5'b00010));
    step();
    chk("bpm_alert", obs(), o(1, 2, 0, 1, 5'b00010));
    drive(6'b010001);
    step();
    chk("bpm_ack_gap", obs(), o(0, 0, 0, 0, 5'b00000));
    drive(6'b010000);
    for (int i = 0; i < 10; i++) step();
    chk("bpm_no_retrigger", obs(), o(0, 0, 0, 0, 5'b00000));
    $display("seq bpm_debounce done");

    // temp_low presenting, fall preempts, ack returns to temp_low
    drive(6'b000100);
    for (int i = 0; i < 8; i++) step();
    chk("tlow_qualified", obs(), o(0, 0, 0, 0, 5'b01000));
    drive(6'b000000);
    step();
    chk("tlow_alert", obs(), o(1, 4, 0, 1, 5'b01000));
    drive(6'b100000);
    step();
    chk("tlow_fall_pending", obs(), o(1, 4, 0, 1, 5'b01001));
    step();
    chk("fall_preempt", obs(), o(1, 1, 0, 1, 5'b01001));
    drive(6'b000001);
    step();
    chk("fall_ack_gap", obs(), o(0, 0, 0, 0, 5'b01000));
    drive(6'b000000);
    step();
    chk("after_gap_idle", obs(), o(0, 0, 0, 0, 5'b01000));
    step();
    chk("tlow_resumed", obs(), o(1, 4, 0, 1, 5'b01000));
    drive(6'b000001);
    step();
    drive(6'b000000);
    step();
    chk("tlow_cleared", obs(), o(0, 0, 0, 0, 5'b00000));
    $display("seq preempt done");

    // Fall pulse unacknowledged: escalation after 100 cycles, blink every 10
    drive(6'b100000);
    step();
    drive(6'b000000);
    chk("fall_pending", obs(), o(0, 0, 0, 0, 5'b00001));
    step();
    chk("fall_alert", obs(), o(1, 1, 0, 1, 5'b00001));
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 99) chk_bit("esc_not_yet", escalate, 1'b0);
      if (k == 100) chk("esc_entered", obs(), o(1, 1, 1, 1, 5'b00001));
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 9)  chk_bit("blink_9", buzzer, 1'b1);
      if (k == 10) chk_bit("blink_10", buzzer, 1'b0);
      if (k == 19) chk_bit("blink_19", buzzer, 1'b0);
      if (k == 20) chk_bit("blink_20", buzzer, 1'b1);
    end
    $display("seq escalate done");

    // Asynchronous reset mid-ESCALATE with fall_alarm held high through release
    drive(6'b100000);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset", obs(), o(0, 0, 0, 0, 5'b00000));
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("held_fall_no_edge", obs(), o(0, 0, 0, 0, 5'b00000));
    drive(6'b000000);
    step();
    chk("post_reset_idle", obs(), o(0, 0, 0, 0, 5'b00000));
    $display("seq reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
